// File: rtl/ula_logico.sv
// Registered 6-bit logic unit: bitwise op picked by sel[2:0] when sel[3]=1; sel 0..7 yields zero.
// Latency 1 cycle, one result per cycle; no backpressure, each edge overwrites the previous result.
module ula_logico (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] A,
    input  logic [5:0] B,
    input  logic [3:0] sel,
    output logic [5:0] saida_logica,
    output logic       zero,
    output logic       valid
);

    logic [5:0] saida_d, saida_q;
    logic       zero_d, zero_q;
    logic       valid_d, valid_q;

    always_comb begin
        saida_d = 6'b000000;
        valid_d = 1'b0;
        if (sel[3]) begin
            valid_d = 1'b1;
            case (sel[2:0])
                3'd0: saida_d = A & B;
                3'd1: saida_d = A | B;
                3'd2: saida_d = A ^ B;
                3'd3: saida_d = ~(A & B);
                3'd4: saida_d = ~(A | B);
                3'd5: saida_d = ~(A ^ B);
                3'd6: saida_d = ~A;
                default: saida_d = ~B;
            endcase
        end
        // Flag follows the value being loaded, so the reserved-opcode case also reports zero.
        zero_d = (saida_d == 6'b000000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saida_q <= 6'b000000;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            saida_q <= saida_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign saida_logica = saida_q;
    assign zero         = zero_q;
    assign valid        = valid_q;

endmodule

// File: tb/tb_ula_logico.sv
// Directed and random checks of ula_logico against hand-computed values and a bitwise model.
module tb_ula_logico;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] A, B;
    logic [3:0] sel;
    logic [5:0] saida_logica;
    logic       zero, valid;

    int n_cmp = 0;
    int n_bad = 0;

    ula_logico dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .sel         (sel),
        .saida_logica(saida_logica),
        .zero        (zero),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply operands on the falling edge, then land 1 time unit after the rising edge.
    task automatic step(input logic [5:0] a, input logic [5:0] b, input logic [3:0] s);
        @(negedge clk);
        A = a; B = b; sel = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ref_op(input logic [5:0] a, input logic [5:0] b, input logic [3:0] s);
        logic [5:0] r;
        r = 6'b000000;
        if (s == 4'd8)  r = a & b;
        if (s == 4'd9)  r = a | b;
        if (s == 4'd10) r = a ^ b;
        if (s == 4'd11) r = ~(a & b);
        if (s == 4'd12) r = ~(a | b);
        if (s == 4'd13) r = ~(a ^ b);
        if (s == 4'd14) r = ~a;
        if (s == 4'd15) r = ~b;
        return r;
    endfunction

    logic [5:0] sweep_exp [8];
    logic [5:0] ra, rb, rexp;
    logic [3:0] rs;

    initial begin
        sweep_exp[0] = 6'b001000;
        sweep_exp[1] = 6'b111110;
        sweep_exp[2] = 6'b110110;
        sweep_exp[3] = 6'b110111;
        sweep_exp[4] = 6'b000001;
        sweep_exp[5] = 6'b001001;
        sweep_exp[6] = 6'b010011;
        sweep_exp[7] = 6'b100101;

        rst = 1'b1; A = 6'd0; B = 6'd0; sel = 4'd0;
        #2;
        chk("rst_saida", {2'b0, saida_logica}, 8'h00);
        chk("rst_zero", {7'b0, zero}, 8'h01);
        chk("rst_valid", {7'b0, valid}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Sweep all logic opcodes with A=44, B=26.
        for (int i = 0; i < 8; i++) begin
            step(6'd44, 6'd26, 4'(8 + i));
            chk($sformatf("sweep_saida_sel%0d", 8 + i), {2'b0, saida_logica}, {2'b0, sweep_exp[i]});
            chk($sformatf("sweep_zero_sel%0d", 8 + i), {7'b0, zero}, 8'h00);
            chk($sformatf("sweep_valid_sel%0d", 8 + i), {7'b0, valid}, 8'h01);
        end

        step(6'b111111, 6'b111111, 4'd10);
        chk("allones_xor_saida", {2'b0, saida_logica}, 8'h00);
        chk("allones_xor_zero", {7'b0, zero}, 8'h01);
        chk("allones_xor_valid", {7'b0, valid}, 8'h01);
        step(6'b111111, 6'b111111, 4'd13);
        chk("allones_xnor_saida", {2'b0, saida_logica}, 8'h3f);
        chk("allones_xnor_zero", {7'b0, zero}, 8'h00);

        step(6'd0, 6'd0, 4'd12);
        chk("zeros_nor_saida", {2'b0, saida_logica}, 8'h3f);
        step(6'd0, 6'd0, 4'd8);
        chk("zeros_and_saida", {2'b0, saida_logica}, 8'h00);
        chk("zeros_and_zero", {7'b0, zero}, 8'h01);

        step(6'd44, 6'd26, 4'd3);
        chk("reserved_saida", {2'b0, saida_logica}, 8'h00);
        chk("reserved_zero", {7'b0, zero}, 8'h01);
        chk("reserved_valid", {7'b0, valid}, 8'h00);

        // Asynchronous reset between edges, then recovery on the next edge.
        step(6'd44, 6'd26, 4'd9);
        chk("pre_rst_saida", {2'b0, saida_logica}, 8'h3e);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_saida", {2'b0, saida_logica}, 8'h00);
        chk("midrst_zero", {7'b0, zero}, 8'h01);
        chk("midrst_valid", {7'b0, valid}, 8'h00);
        #1;
        rst = 1'b0;
        sel = 4'd10;
        @(posedge clk);
        #1;
        chk("post_rst_saida", {2'b0, saida_logica}, 8'h36);
        chk("post_rst_valid", {7'b0, valid}, 8'h01);

        // Inputs changing between edges must not reach the outputs.
        A = 6'd0; B = 6'd63; sel = 4'd3;
        #2;
        chk("hold_saida", {2'b0, saida_logica}, 8'h36);
        chk("hold_valid", {7'b0, valid}, 8'h01);

        for (int p = 0; p < 5; p++) begin
            ra = 6'($urandom_range(0, 63));
            rb = 6'($urandom_range(0, 63));
            for (int s = 8; s < 16; s++) begin
                rs = 4'(s);
                rexp = ref_op(ra, rb, rs);
                step(ra, rb, rs);
                chk($sformatf("rand%0d_saida_sel%0d", p, s), {2'b0, saida_logica}, {2'b0, rexp});
                chk($sformatf("rand%0d_zero_sel%0d", p, s), {7'b0, zero}, {7'b0, rexp == 6'd0});
                chk($sformatf("rand%0d_valid_sel%0d", p, s), {7'b0, valid}, 8'h01);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
